// File: rtl/router_pkg.sv
// Constants shared by the router output-channel slice: packet width and
// virtual-channel numbering (even phase feeds VC0, odd phase feeds VC1).
package router_pkg;

    localparam int DATA_W = 64;
    localparam int VC_NUM = 2;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    // The link side always drains the VC opposite to the current write phase.
    function automatic logic drain_vc(input logic polarity);
        return ~polarity;
    endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single virtual-channel FIFO: power-of-two depth, wrapping pointers and an
// occupancy counter; the head entry is presented combinationally.
module router_vc_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/router_output_channel.sv
// Router output port buffer: two phase-steered VC FIFOs and the registered link
// driver. Optional counters are enabled by defining ROUTER_OC_STATS_EN.
module router_output_channel #(
    parameter int DATA_W   = router_pkg::DATA_W,
    parameter int VC_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              send,
    output logic [DATA_W-1:0] data_out,
`ifdef ROUTER_OC_STATS_EN
    output logic [15:0]       tx_count,
    output logic [15:0]       drop_count,
`endif
    output logic              out_vc
);

    import router_pkg::*;

    localparam int CNT_W = $clog2(VC_DEPTH) + 1;

    logic [DATA_W-1:0] vc_head  [VC_NUM];
    logic [CNT_W-1:0]  vc_count [VC_NUM];
    logic              vc_full  [VC_NUM];
    logic              vc_empty [VC_NUM];
    logic              vc_push  [VC_NUM];
    logic              vc_pop   [VC_NUM];

    logic              pop_vc;
    logic              can_pop;

    logic              send_q, send_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_vc_q, out_vc_d;

    assign pop_vc   = drain_vc(polarity);
    assign in_ready = !vc_full[polarity];
    assign can_pop  = out_ready && !vc_empty[pop_vc];

    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            localparam logic VC_ID = (gi == 0) ? VC_EVEN : VC_ODD;

            assign vc_push[gi] = in_valid && in_ready && (polarity == VC_ID);
            assign vc_pop[gi]  = can_pop && (pop_vc == VC_ID);

            router_vc_fifo #(
                .WIDTH (DATA_W),
                .DEPTH (VC_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (reset),
                .push      (vc_push[gi]),
                .push_data (in_data),
                .pop       (vc_pop[gi]),
                .head      (vc_head[gi]),
                .count     (vc_count[gi]),
                .full      (vc_full[gi]),
                .empty     (vc_empty[gi])
            );

            always_ff @(posedge clk) begin
                if (!reset) begin
                    assert (vc_count[gi] <= CNT_W'(VC_DEPTH));
                end
            end
        end
    endgenerate

    always_comb begin
        send_d     = 1'b0;
        data_out_d = '0;
        out_vc_d   = 1'b0;
        if (can_pop) begin
            send_d     = 1'b1;
            data_out_d = vc_head[pop_vc];
            out_vc_d   = pop_vc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_q     <= 1'b0;
            data_out_q <= '0;
            out_vc_q   <= 1'b0;
        end else begin
            send_q     <= send_d;
            data_out_q <= data_out_d;
            out_vc_q   <= out_vc_d;
        end
    end

    assign send     = send_q;
    assign data_out = data_out_q;
    assign out_vc   = out_vc_q;

`ifdef ROUTER_OC_STATS_EN
    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    // tx_count tracks each send as it is registered; drops saturate.
    always_comb begin
        tx_count_d   = tx_count_q;
        drop_count_d = drop_count_q;
        if (send_d) begin
            tx_count_d = tx_count_q + 16'd1;
        end
        if (in_valid && !in_ready && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            tx_count_q   <= tx_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tx_count   = tx_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_router_output_channel.sv
// Directed bench for router_output_channel; optional counters are checked
// when ROUTER_OC_STATS_EN is defined.
module tb_router_output_channel;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic        send;
    logic [63:0] data_out;
    logic        out_vc;
`ifdef ROUTER_OC_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] drop_count;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    logic pol     = 1'b0;

    router_output_channel #(
        .DATA_W   (64),
        .VC_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .send       (send),
        .data_out   (data_out),
`ifdef ROUTER_OC_STATS_EN
        .tx_count   (tx_count),
        .drop_count (drop_count),
`endif
        .out_vc     (out_vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [63:0] d, input logic ordy);
        polarity  = pol;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pol = ~pol;
        if (send) $display("[TB] t=%0t send vc=%0d data=%0h", $time, out_vc, data_out);
    endtask

    task automatic align_even();
        if (pol) begin
            set_in(1'b0, 64'h0, 1'b0);
            tick();
        end
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_send", send, 1'b0);
        chk("rst_data", data_out, 64'h0);
        chk("rst_vc", out_vc, 1'b0);
        #2 reset = 1'b0;
    endtask

    logic [63:0] exp_d [4];
    logic        exp_v [4];

    initial begin
        reset     = 1'b1;
        polarity  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        pol = 1'b0;

        // Reset state
        set_in(1'b0, 64'h0, 1'b0);
        chk("init_send", send, 1'b0);
        chk("init_data", data_out, 64'h0);
        chk("init_vc", out_vc, 1'b0);
        chk("init_in_ready", in_ready, 1'b1);
`ifdef ROUTER_OC_STATS_EN
        chk("init_tx", tx_count, 16'd0);
        chk("init_drop", drop_count, 16'd0);
`endif

        // Zero payload travels like any other packet
        set_in(1'b1, 64'h0, 1'b1); tick();
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("zero_send", send, 1'b1);
        chk("zero_data", data_out, 64'h0);
        chk("zero_vc", out_vc, 1'b0);
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("zero_after", send, 1'b0);

        // Fill VC0 with out_ready low, then drain in order
        align_even();
        set_in(1'b1, 64'hA1, 1'b0); chk("a1_ready", in_ready, 1'b1); tick();
        set_in(1'b0, 64'h0, 1'b0); tick();
        set_in(1'b1, 64'hA2, 1'b0); chk("a2_ready", in_ready, 1'b1); tick();
        set_in(1'b0, 64'h0, 1'b0); tick();
        set_in(1'b0, 64'h0, 1'b0); chk("vc0_full", in_ready, 1'b0); tick();
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("a1_send", send, 1'b1);
        chk("a1_data", data_out, 64'hA1);
        chk("a1_vc", out_vc, 1'b0);
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("a_gap", send, 1'b0);
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("a2_send", send, 1'b1);
        chk("a2_data", data_out, 64'hA2);

        // Alternating-phase streaming: send stays high
        align_even();
        for (int i = 0; i < 7; i++) begin
            logic [63:0] d;
            d = pol ? 64'h22 : 64'h11;
            set_in(i < 6, d, 1'b1);
            tick();
            if (i >= 1) begin
                chk("alt_send", send, 1'b1);
                chk("alt_data", data_out, (i % 2 == 1) ? 64'h11 : 64'h22);
                chk("alt_vc", out_vc, (i % 2 == 1) ? 1'b0 : 1'b1);
            end
        end
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("alt_end", send, 1'b0);

        // Both VCs full, long back-pressure, then release
        align_even();
        set_in(1'b1, 64'hB0, 1'b0); tick();
        set_in(1'b1, 64'hB1, 1'b0); tick();
        set_in(1'b1, 64'hB2, 1'b0); tick();
        set_in(1'b1, 64'hB3, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 64'h0, 1'b0);
            if (i < 2) chk("hold_in_ready", in_ready, 1'b0);
            tick();
            chk("hold_send", send, 1'b0);
        end
        exp_d[0] = 64'hB1; exp_v[0] = 1'b1;
        exp_d[1] = 64'hB0; exp_v[1] = 1'b0;
        exp_d[2] = 64'hB3; exp_v[2] = 1'b1;
        exp_d[3] = 64'hB2; exp_v[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 64'h0, 1'b1);
            tick();
            chk("rel_send", send, 1'b1);
            chk("rel_data", data_out, exp_d[i]);
            chk("rel_vc", out_vc, exp_v[i]);
        end
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("rel_empty", send, 1'b0);

        // Asynchronous reset mid-cycle with packets buffered
        align_even();
        set_in(1'b1, 64'hD0, 1'b0); tick();
        set_in(1'b1, 64'hD1, 1'b0); tick();
        set_in(1'b1, 64'hD2, 1'b0); tick();
        set_in(1'b1, 64'hD3, 1'b0); tick();
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("pre_rst_send", send, 1'b1);
        chk("pre_rst_data", data_out, 64'hD1);
        async_reset();
        polarity = 1'b0; #1;
        chk("post_rst_ready0", in_ready, 1'b1);
        polarity = 1'b1; #1;
        chk("post_rst_ready1", in_ready, 1'b1);
        pol = 1'b0;
`ifdef ROUTER_OC_STATS_EN
        chk("post_rst_tx", tx_count, 16'd0);
        chk("post_rst_drop", drop_count, 16'd0);
`endif
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("post_rst_send0", send, 1'b0);
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("post_rst_send1", send, 1'b0);

        // Five sends and two rejected writes
        align_even();
        set_in(1'b1, 64'hE0, 1'b0); tick();
        set_in(1'b1, 64'hE1, 1'b0); tick();
        set_in(1'b1, 64'hE2, 1'b0); tick();
        set_in(1'b1, 64'hE3, 1'b0); tick();
        set_in(1'b1, 64'hEE, 1'b0); chk("drop0_ready", in_ready, 1'b0); tick();
        set_in(1'b1, 64'hEF, 1'b0); chk("drop1_ready", in_ready, 1'b0); tick();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 64'h0, 1'b1);
            tick();
            chk("st_send", send, (i < 4) ? 1'b1 : 1'b0);
        end
        set_in(1'b1, 64'hF5, 1'b1); tick();
        set_in(1'b0, 64'h0, 1'b1); tick();
        chk("st5_data", data_out, 64'hF5);
        set_in(1'b0, 64'h0, 1'b0); tick();
`ifdef ROUTER_OC_STATS_EN
        chk("tx_count", tx_count, 16'd5);
        chk("drop_count", drop_count, 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
